// File: rtl/pwm_secuenciador_pkg.sv
// Shared definitions for the PWM sequencer: FSM state encoding and PWM defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_secuenciador_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } estado_t;

    // Default resolution and prescaler tap shared with the other PWM blocks.
    localparam int PWM_R_DEF = 11;
    localparam int PWM_F_DEF = 2;

endpackage

// File: rtl/pwm_contador.sv
// Prescaled PWM counter: one tick every 2^(F+1) clk, Q advances on tick.
// Latency: period_end is combinational from the counter registers.
// Backpressure: none; counter is cleared whenever run is low.
//
// Ports: clk, reset (sync active-low), run (count enable / clear when low),
//        q (R-bit PWM position), period_end (last tick of the PWM period).
module pwm_contador
    import pwm_secuenciador_pkg::*;
#(
    parameter int R = PWM_R_DEF,
    parameter int F = PWM_F_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    output logic [R-1:0] q,
    output logic         period_end
);

    logic [F:0] pre;
    logic       tick;

    assign tick       = run && (&pre);
    assign period_end = tick && (&q);

    always_ff @(posedge clk) begin
        if (!reset || !run) begin
            pre <= '0;
            q   <= '0;
        end else begin
            pre <= pre + 1'b1;
            if (tick) begin
                q <= q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_secuenciador.sv
// Duty-cycle sequencer: steps a (duty, hold) table, changing duty only at PWM period ends.
// Latency: start at edge t -> busy and pwm_out valid from t+1; stop takes effect next edge.
// Backpressure: none; table writes are always accepted, start is ignored while running.
//
// Ports: clk, reset (sync active-low), start/stop pulses, loop level,
//        wr_en/wr_addr/wr_duty/wr_hold table write port,
//        pwm_out, step (active entry), busy (in RUN), seq_done (one-shot end pulse).
module pwm_secuenciador
    import pwm_secuenciador_pkg::*;
#(
    parameter int R       = PWM_R_DEF,
    parameter int F       = PWM_F_DEF,
    parameter int N_PASOS = 8,
    parameter int HOLD_W  = 8,
    localparam int AW     = $clog2(N_PASOS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [R-1:0]      wr_duty,
    input  logic [HOLD_W-1:0] wr_hold,
    output logic              pwm_out,
    output logic [AW-1:0]     step,
    output logic              busy,
    output logic              seq_done
);

    localparam logic [AW-1:0] ULTIMO = AW'(N_PASOS - 1);

    logic [R-1:0]      duty_tab [N_PASOS];
    logic [HOLD_W-1:0] hold_tab [N_PASOS];

    estado_t           state, state_nxt;
    logic [AW-1:0]     step_nxt, step_inc;
    logic [R-1:0]      duty_act, duty_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              done_nxt;

    logic [R-1:0]      q;
    logic              period_end;
    logic              run;

    // Gating run with stop clears the counter on the same edge that leaves RUN,
    // so Q is already 0 in the first IDLE cycle.
    assign busy = (state == ST_RUN);
    assign run  = busy && !stop;

    pwm_contador #(
        .R (R),
        .F (F)
    ) u_contador (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .q          (q),
        .period_end (period_end)
    );

    assign pwm_out  = busy && (q < duty_act);
    assign step_inc = step + 1'b1;

    // Table reads here see the pre-write contents, so a load coinciding with a
    // write to the same entry takes the old value.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        duty_nxt  = duty_act;
        hold_nxt  = hold_cnt;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nxt = ST_RUN;
                    step_nxt  = '0;
                    duty_nxt  = duty_tab[0];
                    hold_nxt  = hold_tab[0];
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                    step_nxt  = '0;
                end else if (period_end) begin
                    if (hold_cnt != '0) begin
                        hold_nxt = hold_cnt - 1'b1;
                    end else if (step != ULTIMO) begin
                        step_nxt = step_inc;
                        duty_nxt = duty_tab[step_inc];
                        hold_nxt = hold_tab[step_inc];
                    end else if (loop) begin
                        step_nxt = '0;
                        duty_nxt = duty_tab[0];
                        hold_nxt = hold_tab[0];
                    end else begin
                        state_nxt = ST_IDLE;
                        step_nxt  = '0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            step     <= '0;
            duty_act <= '0;
            hold_cnt <= '0;
            seq_done <= 1'b0;
            for (int i = 0; i < N_PASOS; i++) begin
                duty_tab[i] <= '0;
                hold_tab[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            duty_act <= duty_nxt;
            hold_cnt <= hold_nxt;
            seq_done <= done_nxt;
            if (wr_en) begin
                duty_tab[wr_addr] <= wr_duty;
                hold_tab[wr_addr] <= wr_hold;
            end
        end
    end

endmodule
